spi_rx_fsm: RTL
===============

// Module: spi_rx_fsm
// PURPOSE
//  SPI receive end for the serial link driven by spi_fsm (idle-high sclk, mosi changes on sclk fall, MSB first).
//  Oversamples sclk/mosi with the system clock and captures one bits-wide word per armed frame on sclk rising edges.
//  Presents the word with a level done flag (fin) and handshakes exactly like the transmitter: armed by en, released by en low.
//  Sits on the data-capture side of the voltmeter datapath, feeding the display/processing logic.
// PARAMETERS
//  bits     8   word length in bits; bit counter width $clog2(bits)+1
//  TIMEOUT  64  clk cycles without an sclk rising edge, after the first edge, that abort a frame
// PORTS
//  clk       in   1     system clock, all logic on posedge
//  rst       in   1     synchronous reset, active-low (rst==0 at posedge clk resets)
//  en        in   1     arm/hold request; level, same semantics as the transmitter's en
//  sclk      in   1     serial clock, asynchronous to clk, idle high
//  mosi      in   1     serial data, asynchronous to clk
//  data_out  out  bits  received word, MSB = first bit received; valid while fin==1
//  fin       out  1     high while in DONE
//  busy      out  1     high while in RECV
//  err       out  1     one-cycle pulse on frame abort (timeout)
// BEHAVIOUR
//  Reset: state IDLE, data_out=0, fin=0, busy=0, err=0, shift reg=0, bit cnt=0, timeout cnt=0,
//   sync/edge flops on sclk reset to 1 (no false rise), mosi sync flops to 0.
//  Input sync: two flops each on sclk and mosi; rise = sclk_s & ~sclk_d. Sample uses mosi_s in the rise cycle.
//  Latency: physical sclk rise -> bit shifted in 3 clk later. Requires sclk high and low phases >= 4 clk each.
//  States:
//   IDLE: on en=1 -> RECV; clear shift reg, bit cnt, timeout cnt. Rises while in IDLE are ignored.
//   RECV: busy=1. On rise: shr <= {shr[bits-2:0], mosi_s}; cnt <= cnt+1; timeout cnt cleared.
//         When cnt reaches bits (same cycle as the bits-th shift completes, i.e. next cycle) -> DONE; data_out <= shr.
//         en dropped in RECV -> IDLE, no fin, no err, data_out unchanged.
//   DONE: fin=1; data_out held. en=1 stays DONE; en=0 -> IDLE. Rises in DONE ignored (extra sclk pulses dropped).
//  data_out updates only on RECV->DONE transition; otherwise holds last completed word.
//  Simultaneous: rise in the same cycle as en falls in RECV -> abort wins, sample discarded.
//  Minimum frame-to-frame: DONE -> IDLE -> RECV needs en low for >= 1 clk.
//  Reset mid-frame: next cycle all state as reset values; partial word lost, no err.
// CONFIGURATION
//  SPI_RX_TIMEOUT_EN defined: in RECV, after the first rise, a counter increments each clk with no rise and
//   clears on rise; reaching TIMEOUT -> IDLE, err=1 for exactly one clk, data_out unchanged.
//   Before the first rise RECV waits indefinitely.
//  Not defined: no timeout counter, err tied 0; RECV leaves only via bits rises or en low.
// TESTING
//  1 Reset: hold rst=0 3 clk with sclk=1,mosi=1 -> data_out=0, fin=0, busy=0, err=0.
//  2 Loopback: spi_fsm (bits=8) data2trans=8'hA5 -> this block, en shared -> fin=1, data_out=8'hA5 within 10 clk of tx fin.
//  3 Back-to-back: words 8'h00, 8'hFF, 8'h3C with en low 1 clk between -> each fin shows matching data_out.
//  4 Abort: en low after 4 rises of 8'hC3 -> IDLE, fin never 1, data_out keeps previous 8'hA5, err=0.
//  5 Timeout (macro on, TIMEOUT=64): stop sclk high after 5 rises -> err pulse 64 clk after 5th sampled rise,
//    busy=0 next cycle, data_out unchanged; macro off -> busy stays 1, err stays 0.
//  6 Extra pulses: 10 sclk rises with mosi pattern 8'h5A then 2 x 1 -> data_out=8'h5A, fin held while en=1.

Source files
------------

// File: rtl/spi_rx_fsm_if.sv
// spi_rx_fsm_if -- bus bundle for the SPI receive FSM.
//   master modport (link/stimulus side): drives en, sclk, mosi;
//                                         observes data_out, fin, busy, err.
//   slave modport  (spi_rx_fsm side):     observes en, sclk, mosi;
//                                         drives data_out, fin, busy, err.
//   en       arm/hold request level
//   sclk     serial clock, idle high, asynchronous to clk
//   mosi     serial data, changes on sclk fall, MSB first
//   data_out last completed word, valid while fin is high
//   fin      word complete (level, held until en drops)
//   busy     frame in progress
//   err      one-cycle frame abort pulse (timeout build only)
interface spi_rx_fsm_if #(
    parameter int unsigned bits = 8
);
    logic            en;
    logic            sclk;
    logic            mosi;
    logic [bits-1:0] data_out;
    logic            fin;
    logic            busy;
    logic            err;

    modport master (
        output en, sclk, mosi,
        input  data_out, fin, busy, err
    );

    modport slave (
        input  en, sclk, mosi,
        output data_out, fin, busy, err
    );
endinterface

// File: rtl/spi_rx_fsm.sv
// spi_rx_fsm -- SPI receive end (idle-high sclk, sample on sclk rise, MSB first).
// Oversamples sclk/mosi with clk, captures one bits-wide word per armed frame
// and holds it with a level fin flag until en is released.
// Ports:
//   clk   system clock, all logic on posedge
//   rst   synchronous reset, active low
//   bus   spi_rx_fsm_if.slave: en/sclk/mosi in, data_out/fin/busy/err out
// Parameters:
//   bits     word length (>= 2)
//   TIMEOUT  clk cycles without an sclk rise (after the first) that abort a frame
// Build option:
//   SPI_RX_TIMEOUT_EN  enables the inter-edge timeout and the err pulse;
//                      without it err is tied low and RECV never times out.
module spi_rx_fsm #(
    parameter int unsigned bits    = 8,
    parameter int unsigned TIMEOUT = 64
) (
    input logic         clk,
    input logic         rst,
    spi_rx_fsm_if.slave bus
);
    localparam int unsigned CW = $clog2(bits) + 1;

    typedef enum logic [1:0] {
        IDLE,
        RECV,
        DONE
    } state_t;

    state_t          state_q, state_d;
    logic [bits-1:0] shr_q, shr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [bits-1:0] dout_q, dout_d;

    // Two-flop synchronisers plus a delayed copy of sclk for edge detection.
    // sclk flops reset high so an idle-high line never looks like a rise.
    logic sclk_s1_q, sclk_s_q, sclk_d_q;
    logic mosi_s1_q, mosi_s_q;
    logic rise;

    logic fin, busy, err;

`ifdef SPI_RX_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tmo_q, tmo_d;
`endif

    assign rise = sclk_s_q & ~sclk_d_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            shr_q     <= '0;
            cnt_q     <= '0;
            dout_q    <= '0;
            sclk_s1_q <= 1'b1;
            sclk_s_q  <= 1'b1;
            sclk_d_q  <= 1'b1;
            mosi_s1_q <= 1'b0;
            mosi_s_q  <= 1'b0;
`ifdef SPI_RX_TIMEOUT_EN
            tmo_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            shr_q     <= shr_d;
            cnt_q     <= cnt_d;
            dout_q    <= dout_d;
            sclk_s1_q <= bus.sclk;
            sclk_s_q  <= sclk_s1_q;
            sclk_d_q  <= sclk_s_q;
            mosi_s1_q <= bus.mosi;
            mosi_s_q  <= mosi_s1_q;
`ifdef SPI_RX_TIMEOUT_EN
            tmo_q     <= tmo_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        shr_d   = shr_q;
        cnt_d   = cnt_q;
        dout_d  = dout_q;
        fin     = 1'b0;
        busy    = 1'b0;
        err     = 1'b0;
`ifdef SPI_RX_TIMEOUT_EN
        tmo_d   = tmo_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (bus.en) begin
                    state_d = RECV;
                    shr_d   = '0;
                    cnt_d   = '0;
`ifdef SPI_RX_TIMEOUT_EN
                    tmo_d   = '0;
`endif
                end
            end
            RECV: begin
                busy = 1'b1;
                // Priority: en release beats completion, timeout and a
                // coincident rise, so an aborted frame never reports anything.
                if (!bus.en) begin
                    state_d = IDLE;
                end else if (cnt_q == CW'(bits)) begin
                    state_d = DONE;
                    dout_d  = shr_q;
`ifdef SPI_RX_TIMEOUT_EN
                end else if (tmo_q == TW'(TIMEOUT)) begin
                    err     = 1'b1;
                    state_d = IDLE;
`endif
                end else if (rise) begin
                    shr_d = {shr_q[bits-2:0], mosi_s_q};
                    cnt_d = cnt_q + 1'b1;
`ifdef SPI_RX_TIMEOUT_EN
                    tmo_d = '0;
                end else if (cnt_q != '0) begin
                    // Timer only runs once the first edge has arrived.
                    tmo_d = tmo_q + 1'b1;
`endif
                end
            end
            DONE: begin
                fin = 1'b1;
                if (!bus.en) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.data_out = dout_q;
    assign bus.fin      = fin;
    assign bus.busy     = busy;
    assign bus.err      = err;
endmodule
